// File: rtl/dmem_timer_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_timer_unit : data RAM with byte-lane stores, load extension and a
//                   memory-mapped down-counting interrupt timer.  Rev 1.0
// ---------------------------------------------------------------------------
module dmem_timer_unit #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic [2:0]  load,
  input  logic [1:0]  store,
  output logic [31:0] rdata,
  output logic        align_err,
  output logic        irq
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  logic [31:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic ram_hit, timer_hit;
  logic ld_byte, ld_half, ld_signed, ld_mis;
  logic st_byte, st_half, st_mis;
  logic wr_ok;
  logic [3:0]  be;
  logic [31:0] lane_data;
  logic [31:0] tmr_word, rd_word, shifted;
  logic [15:0] half;

  state_t      state, state_n;
  logic        en, mode, im, flag;
  logic        en_n, mode_n, im_n, flag_n;
  logic [31:0] preset, count, count_n;
  logic        tmr_wr, ctrl_wr, preset_wr, expire;

  assign word_idx  = addr[ADDR_WIDTH+1:2];
  assign ram_hit   = (addr[31:ADDR_WIDTH+2] == '0);
  assign timer_hit = (addr[31:4] == TIMER_BASE[31:4]);

  always_comb begin
    ld_byte   = 1'b0;
    ld_half   = 1'b0;
    ld_signed = 1'b0;
    case (load)
      3'b001:  begin ld_byte = 1'b1; ld_signed = 1'b1; end
      3'b010:  ld_byte = 1'b1;
      3'b011:  begin ld_half = 1'b1; ld_signed = 1'b1; end
      3'b100:  ld_half = 1'b1;
      default: ;
    endcase
    st_byte = (store == 2'b10);
    st_half = (store == 2'b01);
  end

  assign ld_mis = ld_byte ? 1'b0 : (ld_half ? addr[0] : |addr[1:0]);
  assign st_mis = st_byte ? 1'b0 : (st_half ? addr[0] : |addr[1:0]);
  assign align_err = !rst && (ld_mis || (mem_write && st_mis));
  assign wr_ok     = mem_write && !rst && !st_mis;

  // Store lanes: replicate the sub-word across the word, enable only the target lanes.
  always_comb begin
    if (st_byte) begin
      be        = 4'b0001 << addr[1:0];
      lane_data = {4{wdata[7:0]}};
    end else if (st_half) begin
      be        = addr[1] ? 4'b1100 : 4'b0011;
      lane_data = {2{wdata[15:0]}};
    end else begin
      be        = 4'b1111;
      lane_data = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && ram_hit) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[word_idx][8*k +: 8] <= lane_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    case (addr[3:2])
      2'd0:    tmr_word = {28'd0, flag, im, mode, en};
      2'd1:    tmr_word = preset;
      2'd2:    tmr_word = count;
      default: tmr_word = 32'd0;
    endcase
  end

  assign rd_word = ram_hit ? mem[word_idx] : (timer_hit ? tmr_word : 32'd0);
  assign shifted = rd_word >> {addr[1:0], 3'b000};
  assign half    = addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    if (rst || ld_mis)
      rdata = 32'd0;
    else if (ld_byte)
      rdata = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
    else if (ld_half)
      rdata = {{16{ld_signed & half[15]}}, half};
    else
      rdata = rd_word;
  end

  // Timer registers accept only full-word stores; sub-word stores fall through silently.
  assign tmr_wr    = wr_ok && timer_hit && !st_byte && !st_half;
  assign ctrl_wr   = tmr_wr && (addr[3:2] == 2'd0);
  assign preset_wr = tmr_wr && (addr[3:2] == 2'd1);
  assign expire    = (state == RUN) && (count == 32'd0);

  always_comb begin
    state_n = state;
    count_n = count;
    en_n    = en;
    mode_n  = mode;
    im_n    = im;
    flag_n  = flag;
    if (ctrl_wr && wdata[3]) flag_n = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_wr && wdata[0]) begin
          state_n = RUN;
          count_n = preset;
        end
      end
      RUN: begin
        if (expire) begin
          flag_n = 1'b1;
          if (mode) begin
            count_n = preset;
          end else begin
            en_n    = 1'b0;
            state_n = IDLE;
          end
        end else begin
          count_n = count - 32'd1;
        end
        if (ctrl_wr) begin
          if (wdata[0]) begin
            state_n = RUN;
          end else begin
            state_n = IDLE;
            count_n = count;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Written control bits take priority over what the expiry would have done.
    if (ctrl_wr) begin
      en_n   = wdata[0];
      mode_n = wdata[1];
      im_n   = wdata[2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      en     <= 1'b0;
      mode   <= 1'b0;
      im     <= 1'b0;
      flag   <= 1'b0;
      preset <= 32'd0;
      count  <= 32'd0;
      irq    <= 1'b0;
    end else begin
      state <= state_n;
      en    <= en_n;
      mode  <= mode_n;
      im    <= im_n;
      flag  <= flag_n;
      count <= count_n;
      irq   <= flag & im;
      if (preset_wr) preset <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_timer_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_timer_unit : scoreboard bench for RAM loads/stores and the timer.
// ---------------------------------------------------------------------------
module tb_dmem_timer_unit;

  localparam logic [31:0] CTRL_A   = 32'h0000_7F00;
  localparam logic [31:0] PRESET_A = 32'h0000_7F04;
  localparam logic [31:0] COUNT_A  = 32'h0000_7F08;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata;
  logic        mem_write;
  logic [2:0]  load;
  logic [1:0]  store;
  logic [31:0] rdata;
  logic        align_err, irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  dmem_timer_unit #(.ADDR_WIDTH(10), .TIMER_BASE(32'h0000_7F00)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .mem_write(mem_write),
    .load(load), .store(store), .rdata(rdata), .align_err(align_err), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] st);
    addr = a; wdata = d; store = st; load = 3'd2; mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [2:0] lt,
                    input logic [31:0] exp);
    addr = a; load = lt; mem_write = 1'b0;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    check(tag_q.pop_front(), rdata, exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; mem_write = 1'b0; load = '0; store = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_irq", {31'd0, irq}, 32'd0);
    rd("rst_ctrl",   CTRL_A,   3'd0, 32'd0);
    rd("rst_preset", PRESET_A, 3'd0, 32'd0);
    rd("rst_count",  COUNT_A,  3'd0, 32'd0);

    // Sub-word extraction and extension
    wr(32'h10, 32'hA1B2_C3D4, 2'd0);
    rd("lw_10",  32'h10, 3'd0, 32'hA1B2_C3D4);
    rd("lb_13",  32'h13, 3'd1, 32'hFFFF_FFA1);
    rd("lbu_13", 32'h13, 3'd2, 32'h0000_00A1);
    tick();
    rd("lh_12",  32'h12, 3'd3, 32'hFFFF_A1B2);
    rd("lhu_12", 32'h12, 3'd4, 32'h0000_A1B2);
    rd("lbu_10", 32'h10, 3'd2, 32'h0000_00D4);

    // Byte-lane stores
    wr(32'h11, 32'h0000_0055, 2'd2);
    rd("sb_lw", 32'h10, 3'd0, 32'hA1B2_55D4);
    wr(32'h12, 32'h0000_1234, 2'd1);
    rd("sh_lw", 32'h10, 3'd0, 32'h1234_55D4);
    rd("lh_10_pos", 32'h10, 3'd3, 32'h0000_55D4);

    // Misalignment
    rd("mis_lw_rdata", 32'h12, 3'd0, 32'd0);
    check("mis_lw_err", {31'd0, align_err}, 32'd1);
    addr = 32'h11; wdata = 32'h0000_BEEF; store = 2'd1; load = 3'd2; mem_write = 1'b1;
    #1;
    check("mis_sh_err", {31'd0, align_err}, 32'd1);
    tick();
    mem_write = 1'b0;
    rd("mis_sh_nowr", 32'h10, 3'd0, 32'h1234_55D4);
    check("ok_err", {31'd0, align_err}, 32'd0);

    // Timer ignores sub-word and COUNT stores
    wr(PRESET_A, 32'h0000_00AA, 2'd1);
    wr(COUNT_A,  32'h0000_0077, 2'd0);
    rd("preset_sh_ign", PRESET_A, 3'd0, 32'd0);
    rd("count_wr_ign",  COUNT_A,  3'd0, 32'd0);

    // One-shot: PRESET=3, CTRL=0x5
    wr(PRESET_A, 32'd3, 2'd0);
    rd("preset_rd", PRESET_A, 3'd0, 32'd3);
    wr(CTRL_A, 32'h5, 2'd0);
    rd("os_cnt3", COUNT_A, 3'd0, 32'd3);
    tick(); rd("os_cnt2", COUNT_A, 3'd0, 32'd2);
    tick(); rd("os_cnt1", COUNT_A, 3'd0, 32'd1);
    tick(); rd("os_cnt0", COUNT_A, 3'd0, 32'd0);
    check("os_flag0", {31'd0, irq}, 32'd0);
    tick();
    rd("os_ctrl_exp", CTRL_A, 3'd0, 32'hC);
    check("os_irq_lag", {31'd0, irq}, 32'd0);
    tick();
    check("os_irq", {31'd0, irq}, 32'd1);
    rd("os_cnt_hold", COUNT_A, 3'd0, 32'd0);
    rd("os_lbu_ctrl", CTRL_A, 3'd2, 32'h0000_000C);
    wr(CTRL_A, 32'h8, 2'd0);
    rd("os_clr", CTRL_A, 3'd0, 32'd0);
    tick();
    check("os_irq_clr", {31'd0, irq}, 32'd0);

    // Auto-reload: PRESET=2, CTRL=0x7
    wr(PRESET_A, 32'd2, 2'd0);
    wr(CTRL_A, 32'h7, 2'd0);
    rd("ar_cnt2", COUNT_A, 3'd0, 32'd2);
    tick(); rd("ar_cnt1", COUNT_A, 3'd0, 32'd1);
    tick(); rd("ar_cnt0", COUNT_A, 3'd0, 32'd0);
    tick();
    rd("ar_exp1_ctrl", CTRL_A, 3'd0, 32'hF);
    rd("ar_reload",    COUNT_A, 3'd0, 32'd2);
    wr(CTRL_A, 32'hF, 2'd0);
    rd("ar_clr", CTRL_A, 3'd0, 32'h7);
    check("ar_irq_seen", {31'd0, irq}, 32'd1);
    tick();
    wr(CTRL_A, 32'hF, 2'd0);
    rd("ar_setwins", CTRL_A, 3'd0, 32'hF);
    rd("ar_reload2", COUNT_A, 3'd0, 32'd2);
    tick();
    check("ar_irq2", {31'd0, irq}, 32'd1);
    wr(CTRL_A, 32'h8, 2'd0);
    rd("ar_stop_ctrl", CTRL_A, 3'd0, 32'd0);
    rd("ar_stop_cnt",  COUNT_A, 3'd0, 32'd1);
    tick();
    check("ar_irq_off", {31'd0, irq}, 32'd0);
    rd("ar_cnt_frozen", COUNT_A, 3'd0, 32'd1);

    // Reset mid-count
    wr(PRESET_A, 32'd9, 2'd0);
    wr(CTRL_A, 32'h5, 2'd0);
    tick(); tick(); tick(); tick();
    rd("mid_cnt5", COUNT_A, 3'd0, 32'd5);
    rst = 1'b1;
    tick();
    rd("rst_rdata0", 32'h10, 3'd0, 32'd0);
    addr = 32'h12; load = 3'd0;
    #1;
    check("rst_err0", {31'd0, align_err}, 32'd0);
    check("rst_irq0", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    rd("rst2_ctrl",   CTRL_A,   3'd0, 32'd0);
    rd("rst2_preset", PRESET_A, 3'd0, 32'd0);
    rd("rst2_count",  COUNT_A,  3'd0, 32'd0);
    rd("ram_kept",    32'h10,   3'd0, 32'h1234_55D4);
    rd("unmapped",    32'h4000_0000, 3'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_timer_unit.md
# dmem_timer_unit

Data-side memory unit sitting directly downstream of the single-cycle CPU core. It consumes the core's ALU address, store data, write strobe and load/store type codes. It returns load data in the same cycle. It contains the word-organised data RAM with byte-lane stores, the sub-word load extraction and extension logic, and a memory-mapped down-counting timer that raises an interrupt.

## Interface
- ADDR_WIDTH, 10, RAM word-address width (RAM = 2^ADDR_WIDTH words).
- TIMER_BASE, 32'h0000_7F00, base byte address of the timer register block (16-byte aligned).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- addr  in  32  byte address, driven from the core's ALU result.
- wdata  in  32  store data, driven from the core's rt read port.
- mem_write  in  1  store strobe; a store commits at the next rising edge.
- load  in  3  load type: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; 101–111 treated as lw.
- store  in  2  store type: 00 sw, 01 sh, 10 sb; 11 treated as sw.
- rdata  out  32  load result, combinational, already aligned and extended.
- align_err  out  1  combinational misalignment flag for the current access.
- irq  out  1  timer interrupt, registered.

## Operation
- Address decode:
  - RAM hit when addr[31:ADDR_WIDTH+2]==0.
  - Timer hit when addr[31:4]==TIMER_BASE[31:4].
  - Anything else is unmapped: reads return 0, writes are ignored.
- Byte order is little-endian; byte k of a word is bits [8k+7:8k].
- Alignment:
  - lw/sw require addr[1:0]==0.
  - lh/lhu/sh require addr[0]==0.
  - lb/lbu/sb never misalign.
  - align_err=1 on a misaligned load type, or on a misaligned store type when mem_write=1.
  - A misaligned access suppresses the write and forces rdata=0.
- Loads: select the word at addr[ADDR_WIDTH+1:2], then the byte or halfword at addr[1:0]. lb and lh sign-extend; lbu and lhu zero-extend.
- Stores to RAM write only the addressed lanes: sw all 4, sh 2, sb 1. Other lanes keep their value.
- Timer registers, word access only:
  - Sub-word stores to the timer are ignored, with no error.
  - Sub-word loads extract from the register word like RAM.
  - base+0 CTRL: bit0 EN, bit1 MODE (0 one-shot, 1 auto-reload), bit2 IM (interrupt mask, 1=enabled), bit3 FLAG. FLAG is read-only as a value; writing 1 to bit3 clears it. Bits 31:4 read 0.
  - base+4 PRESET: read/write, 32 bits.
  - base+8 COUNT: read-only; writes ignored.
  - base+C: reads 0.
- Timer FSM has two states, IDLE and RUN.
  - IDLE → RUN: CTRL write with EN=1. COUNT<=PRESET at that edge.
  - RUN with COUNT!=0: COUNT<=COUNT-1.
  - RUN with COUNT==0 (expiry): FLAG<=1. If MODE=1, COUNT<=PRESET and the FSM stays in RUN. If MODE=0, EN<=0 and the FSM goes to IDLE; COUNT stays 0.
  - RUN → IDLE: CTRL write with EN=0. COUNT holds its value.
  - A CTRL write with EN=1 while in RUN updates MODE/IM only; it does not reload COUNT.
- irq = FLAG & IM, registered; it rises one cycle after FLAG sets.

## Timing
- Reset (rst=1 at an edge):
  - CTRL=0, PRESET=0, COUNT=0, FSM=IDLE, irq=0.
  - RAM contents are not reset.
  - While rst=1, rdata=0, align_err=0, and all writes are suppressed.
- Load latency is 0 cycles (combinational read). Store latency is 1 edge. A load in the cycle after a store to the same word returns the new data.
- Preset N with EN written at edge t: COUNT=N after t; expiry at edge t+N+1; FLAG=1 after t+N+1; irq=1 after t+N+2.
- PRESET=0 in auto-reload mode: expiry on every edge while in RUN.
- Expiry and a FLAG-clear write on the same edge: set wins, so FLAG stays 1.
- Expiry and a CTRL write on the same edge: the written EN/MODE/IM win. If EN=0 is written, the FSM goes to IDLE, but FLAG is still set by the expiry.
- A PRESET write during RUN affects only the next reload or enable.
- rst asserted mid-count: the timer returns to reset values at that edge.

## Test plan
- sw 0xA1B2C3D4 to 0x10, then lb/lbu/lh/lhu at 0x13/0x13/0x12/0x12 -> 0xFFFFFFA1, 0x000000A1, 0xFFFFA1B2, 0x0000A1B2.
- sb 0x55 to 0x11 over word 0xA1B2C3D4 -> lw 0x10 returns 0xA1B255D4; sh 0x1234 to 0x12 -> lw returns 0x123455D4.
- lw at 0x12, and sh at 0x11 with mem_write=1 -> align_err=1, rdata=0, RAM word unchanged.
- PRESET=3, CTRL=0x5 at edge t -> COUNT reads 3,2,1,0; FLAG=1 after t+4; irq=1 after t+5; EN reads 0; COUNT stays 0.
- PRESET=2, CTRL=0x7 -> FLAG sets every 3 cycles; a FLAG-clear write on an expiry edge leaves FLAG=1; write 0x8 to CTRL later -> FLAG=0, EN=0, irq=0 one cycle after.
- rst asserted mid-count with COUNT=5 -> at the next edge CTRL=PRESET=COUNT=0, irq=0; lw of unmapped 0x4000_0000 -> 0.
